// File: rtl/uart_tx_param.sv
// Buffered UART transmitter: write FIFO feeding a start/data/parity/stop serialiser.
// Frame config (parity, stop bits, baud divisor) is latched per frame at the pop.
module uart_tx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_en,
  input  logic                 wr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [15:0]          baud_div,
  input  logic [1:0]           par_mode,
  input  logic                 stop2,
  output logic                 txd,
  output logic                 busy,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic [2:0]           dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [4:0] LAST_SAMPLE = 5'(OVERSAMPLE - 1);
  localparam logic [3:0] LAST_DATA   = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Write FIFO
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 overflow_q;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  // Serialiser
  state_t               state_q;
  logic                 txd_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_bit_q;
  logic                 par_en_q;
  logic                 stop2_q;
  logic                 stop_cnt_q;
  logic [15:0]          div_q;
  logic [15:0]          baud_cnt_q;
  logic [4:0]           sample_cnt_q;
  logic [3:0]           bit_cnt_q;
  logic                 tick, bit_done, last_stop, start_frame;

  assign head = mem_q[rd_ptr_q[AW-1:0]];

  assign tick      = (baud_cnt_q == 16'd0);
  assign bit_done  = tick && (sample_cnt_q == LAST_SAMPLE);
  assign last_stop = (state_q == STOP) && bit_done && (!stop2_q || stop_cnt_q);

  // A new frame starts from IDLE or directly off the end of the last stop bit.
  assign start_frame = tx_en && !empty_q &&
                       ((state_q == IDLE) || last_stop);

  assign push = wr && tx_en && !full_q;
  assign pop  = start_frame;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    empty_d  = (wr_ptr_d == rd_ptr_d);
    full_d   = ((wr_ptr_d ^ rd_ptr_d) == {1'b1, {AW{1'b0}}});
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= wr && tx_en && full_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      txd_q        <= 1'b1;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      par_en_q     <= 1'b0;
      stop2_q      <= 1'b0;
      stop_cnt_q   <= 1'b0;
      div_q        <= '0;
      baud_cnt_q   <= '0;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
    end else if (start_frame) begin
      state_q      <= START;
      txd_q        <= 1'b0;
      shift_q      <= head;
      par_en_q     <= par_mode[0] ^ par_mode[1];
      par_bit_q    <= (^head) ^ par_mode[1];
      stop2_q      <= stop2;
      stop_cnt_q   <= 1'b0;
      div_q        <= baud_div;
      baud_cnt_q   <= baud_div;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
    end else if (state_q != IDLE) begin
      if (tick) begin
        baud_cnt_q   <= div_q;
        sample_cnt_q <= bit_done ? 5'd0 : sample_cnt_q + 5'd1;
      end else begin
        baud_cnt_q <= baud_cnt_q - 16'd1;
      end
      if (bit_done) begin
        case (state_q)
          START: begin
            state_q   <= DATA;
            txd_q     <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= '0;
          end
          DATA: begin
            if (bit_cnt_q == LAST_DATA) begin
              if (par_en_q) begin
                state_q <= PARITY;
                txd_q   <= par_bit_q;
              end else begin
                state_q    <= STOP;
                txd_q      <= 1'b1;
                stop_cnt_q <= 1'b0;
              end
            end else begin
              txd_q     <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
          PARITY: begin
            state_q    <= STOP;
            txd_q      <= 1'b1;
            stop_cnt_q <= 1'b0;
          end
          STOP: begin
            // Back-to-back restart is handled by the start_frame branch above.
            if (stop2_q && !stop_cnt_q) begin
              stop_cnt_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
          default: begin
            state_q <= IDLE;
            txd_q   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign txd       = txd_q;
  assign busy      = (state_q != IDLE) || !empty_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

endmodule
